// File: rtl/wishbone2ram_lat_bridge.sv
// Wishbone classic slave to synchronous-RAM master bridge with configurable read latency,
// an address window that answers with err, registered one-cycle acks and abort handling.
module wishbone2ram_lat_bridge #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int                    RD_LAT     = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SIZE_LOG2  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wishbone_cyc_i,
  input  logic                  wishbone_stb_i,
  input  logic                  wishbone_we_i,
  input  logic [ADDR_WIDTH-1:0] wishbone_addr_i,
  input  logic [DATA_WIDTH-1:0] wishbone_data_i,
  input  logic [SEL_WIDTH-1:0]  wishbone_sel_i,
  output logic [DATA_WIDTH-1:0] wishbone_data_o,
  output logic                  wishbone_ack_o,
  output logic                  wishbone_err_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [SEL_WIDTH-1:0]  ram_sel_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_t                state, state_nx;
  logic [2:0]            cnt, cnt_nx;
  logic                  ce_nx, we_nx, ack_nx, err_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] data_nx, rdata_nx;
  logic [SEL_WIDTH-1:0]  sel_nx;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window;

  // A base-aligned window means any address outside it leaves high offset bits set.
  assign offset    = wishbone_addr_i - BASE_ADDR;
  assign in_window = ((offset >> SIZE_LOG2) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      ram_ce_o        <= 1'b0;
      ram_we_o        <= 1'b0;
      ram_addr_o      <= '0;
      ram_data_o      <= '0;
      ram_sel_o       <= '0;
      wishbone_data_o <= '0;
      wishbone_ack_o  <= 1'b0;
      wishbone_err_o  <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      ram_ce_o        <= ce_nx;
      ram_we_o        <= we_nx;
      ram_addr_o      <= addr_nx;
      ram_data_o      <= data_nx;
      ram_sel_o       <= sel_nx;
      wishbone_data_o <= rdata_nx;
      wishbone_ack_o  <= ack_nx;
      wishbone_err_o  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ce_nx    = 1'b0;
    we_nx    = 1'b0;
    addr_nx  = ram_addr_o;
    data_nx  = ram_data_o;
    sel_nx   = ram_sel_o;
    rdata_nx = wishbone_data_o;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (wishbone_cyc_i && wishbone_stb_i) begin
          if (in_window && (wishbone_sel_i != '0)) begin
            ce_nx    = 1'b1;
            we_nx    = wishbone_we_i;
            addr_nx  = offset;
            data_nx  = wishbone_data_i;
            sel_nx   = wishbone_sel_i;
            state_nx = ACCESS;
          end else begin
            err_nx   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      // ram_we_o still carries the direction of the access issued on the previous edge.
      ACCESS: begin
        if (ram_we_o) begin
          ack_nx   = wishbone_cyc_i;
          state_nx = RESP;
        end else begin
          cnt_nx   = LAT_INIT;
          state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == 3'd0) begin
          rdata_nx = ram_data_i;
          ack_nx   = wishbone_cyc_i;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      // The master still holds stb on the edge where it samples ack, so ignore it here.
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone2ram_lat_bridge.sv
// Scoreboard bench for wishbone2ram_lat_bridge: one instance with RD_LAT=1, one with RD_LAT=3,
// each with its own synchronous RAM model; a monitor checks every ack/err against queued expectations.
module tb_wishbone2ram_lat_bridge;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    bit          is_err;
    int          cycle;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel [2];
  logic [31:0] rdata [2];
  logic        ack [2];
  logic        err [2];
  logic        ce  [2];
  logic        rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rdat [2];
  logic [3:0]  rsel [2];
  logic [31:0] ram_rd [2];

  logic [31:0] mem [2][256];
  logic [31:0] pipe [2][3];

  int          cnt = 0;
  int          vectors = 0;
  int          errors = 0;
  int          ce_cnt [2] = '{0, 0};
  int          ce_exp [2] = '{0, 0};
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};
  logic        prev_resp [2] = '{1'b0, 1'b0};
  exp_t        q0 [$];
  exp_t        q1 [$];

  logic [31:0] b2b_wd [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'hAAAA_5555};
  logic [3:0]  b2b_ws [4] = '{4'hF, 4'hF, 4'hF, 4'h3};
  logic [31:0] b2b_rd [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h0000_5555};

  always #5 clk = ~clk;

  wishbone2ram_lat_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .RD_LAT(1),
                            .BASE_ADDR(BASE), .SIZE_LOG2(16)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .wishbone_cyc_i(cyc[0]), .wishbone_stb_i(stb[0]), .wishbone_we_i(we[0]),
    .wishbone_addr_i(addr[0]), .wishbone_data_i(wdata[0]), .wishbone_sel_i(sel[0]),
    .wishbone_data_o(rdata[0]), .wishbone_ack_o(ack[0]), .wishbone_err_o(err[0]),
    .ram_ce_o(ce[0]), .ram_we_o(rwe[0]), .ram_addr_o(raddr[0]), .ram_data_o(rdat[0]),
    .ram_sel_o(rsel[0]), .ram_data_i(ram_rd[0])
  );

  wishbone2ram_lat_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .RD_LAT(3),
                            .BASE_ADDR(BASE), .SIZE_LOG2(16)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .wishbone_cyc_i(cyc[1]), .wishbone_stb_i(stb[1]), .wishbone_we_i(we[1]),
    .wishbone_addr_i(addr[1]), .wishbone_data_i(wdata[1]), .wishbone_sel_i(sel[1]),
    .wishbone_data_o(rdata[1]), .wishbone_ack_o(ack[1]), .wishbone_err_o(err[1]),
    .ram_ce_o(ce[1]), .ram_we_o(rwe[1]), .ram_addr_o(raddr[1]), .ram_data_o(rdat[1]),
    .ram_sel_o(rsel[1]), .ram_data_i(ram_rd[1])
  );

  // RAM model: word 8 preloaded with 0x1234_5678; idle cycles push a poison word down the pipe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 256; i++) mem[p][i] <= (i == 8) ? 32'h1234_5678 : 32'h0;
        for (int k = 0; k < 3; k++) pipe[p][k] <= 32'h0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ce[p] && rwe[p])
          for (int b = 0; b < 4; b++)
            if (rsel[p][b]) mem[p][raddr[p][9:2]][8*b +: 8] <= rdat[p][8*b +: 8];
        pipe[p][0] <= (ce[p] && !rwe[p]) ? mem[p][raddr[p][9:2]] : 32'hBAD0_BAD0;
        pipe[p][1] <= pipe[p][0];
        pipe[p][2] <= pipe[p][1];
      end
    end
  end

  assign ram_rd[0] = pipe[0][0];
  assign ram_rd[1] = pipe[1][2];

  always @(posedge clk) begin
    cnt <= cnt + 1;
    for (int p = 0; p < 2; p++)
      if (rst_n && ce[p]) ce_cnt[p] <= ce_cnt[p] + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cnt);
    end
  endtask

  // Monitor: every ack/err must match the oldest expectation of that port, in kind, cycle and data.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (ack[p] || err[p]) begin
          exp_t e;
          checkOutput("ack_err_overlap", 64'(ack[p] & err[p]), 64'd0);
          checkOutput("resp_consecutive", 64'(prev_resp[p]), 64'd0);
          if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checkOutput("unexpected_resp", 64'd1, 64'd0);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput("resp_kind_err", 64'(err[p]), 64'(e.is_err));
            checkOutput("resp_cycle", 64'(cnt), 64'(e.cycle));
            checkOutput("resp_data", 64'(rdata[p]), 64'(e.data));
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) prev_resp[p] <= rst_n && (ack[p] || err[p]);
  end

  // Issues one request at the current negedge, waits for its termination, then holds stb
  // one more cycle like a real master before releasing the bus.
  task automatic applyStimulus(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input bit expect_err, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    int   lat;
    lat = (p == 0) ? 1 : 3;
    cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; sel[p] = s;
    e.is_err = expect_err;
    e.cycle  = cnt + 1 + (expect_err ? 0 : (w ? 1 : 1 + lat));
    if (!expect_err && !w) last_rd[p] = exp_rd;
    e.data = last_rd[p];
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    if (!expect_err) ce_exp[p]++;
    @(negedge clk);
    checkOutput("ram_ce", 64'(ce[p]), 64'(!expect_err));
    if (!expect_err) begin
      checkOutput("ram_we", 64'(rwe[p]), 64'(w));
      checkOutput("ram_addr", 64'(raddr[p]), 64'(a - BASE));
      checkOutput("ram_sel", 64'(rsel[p]), 64'(s));
      if (w) checkOutput("ram_data", 64'(rdat[p]), 64'(d));
    end
    n = 0;
    while (!(ack[p] || err[p]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("resp_timeout", 64'd0, 64'd1);
    @(negedge clk);
    cyc[p] = 1'b0; stb[p] = 1'b0;
    checkOutput("ce_count", 64'(ce_cnt[p]), 64'(ce_exp[p]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        cyc[p] = 1'($urandom); stb[p] = 1'($urandom); we[p] = 1'($urandom);
        addr[p] = $urandom; wdata[p] = $urandom; sel[p] = 4'($urandom);
      end
      @(negedge clk);
    end
    for (int p = 0; p < 2; p++) begin
      checkOutput("rst_ce", 64'(ce[p]), 64'd0);
      checkOutput("rst_we", 64'(rwe[p]), 64'd0);
      checkOutput("rst_addr", 64'(raddr[p]), 64'd0);
      checkOutput("rst_wdata", 64'(rdat[p]), 64'd0);
      checkOutput("rst_sel", 64'(rsel[p]), 64'd0);
      checkOutput("rst_rdata", 64'(rdata[p]), 64'd0);
      checkOutput("rst_ack", 64'(ack[p]), 64'd0);
      checkOutput("rst_err", 64'(err[p]), 64'd0);
      cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ce_count0", 64'(ce_cnt[0]), 64'd0);
    checkOutput("idle_ce_count1", 64'(ce_cnt[1]), 64'd0);

    $display("[TB] RD_LAT=1: write, reads, window errors");
    applyStimulus(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 1'b0, 32'h1234_5678);
    applyStimulus(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b1, 32'h0);
    applyStimulus(0, 1'b1, 32'h1000_0010, 32'h5555_5555, 4'h0, 1'b1, 32'h0);
    applyStimulus(0, 1'b1, 32'h1000_FFFC, 32'h0BAD_CAFE, 4'hF, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h1000_FFFC, 32'h0, 4'hF, 1'b0, 32'h0BAD_CAFE);
    applyStimulus(0, 1'b0, 32'h1001_0000, 32'h0, 4'hF, 1'b1, 32'h0);
    applyStimulus(0, 1'b1, 32'h0FFF_FFFC, 32'h1, 4'hF, 1'b1, 32'h0);
    applyStimulus(0, 1'b1, 32'h1000_0010, 32'h0000_1111, 4'h3, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_1111);

    $display("[TB] RD_LAT=3: read, write, abort");
    applyStimulus(1, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 1'b0, 32'h1234_5678);
    applyStimulus(1, 1'b1, 32'h1000_0040, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h1000_0040; sel[1] = 4'hF;
    ce_exp[1]++;
    repeat (2) @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (6) @(negedge clk);
    last_rd[1] = 32'hCAFE_F00D;
    checkOutput("abort_data", 64'(rdata[1]), 64'h0000_0000_CAFE_F00D);
    checkOutput("abort_ce_count", 64'(ce_cnt[1]), 64'(ce_exp[1]));
    applyStimulus(1, 1'b1, 32'h1000_0044, 32'h7777_8888, 4'hF, 1'b0, 32'h0);

    $display("[TB] back-to-back writes and reads on both latencies");
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(p, 1'b1, BASE + 32'h100 + 32'(i * 4), b2b_wd[i], b2b_ws[i], 1'b0, 32'h0);
        applyStimulus(p, 1'b0, BASE + 32'h100 + 32'(i * 4), 32'h0, 4'hF, 1'b0, b2b_rd[i]);
      end
    end

    repeat (5) @(negedge clk);
    checkOutput("final_q0_empty", 64'(q0.size()), 64'd0);
    checkOutput("final_q1_empty", 64'(q1.size()), 64'd0);
    checkOutput("final_ce_count0", 64'(ce_cnt[0]), 64'(ce_exp[0]));
    checkOutput("final_ce_count1", 64'(ce_cnt[1]), 64'(ce_exp[1]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wishbone2ram_lat_bridge.md
# wishbone2ram_lat_bridge

Wishbone classic slave to synchronous-RAM master bridge, the parametrised successor of the zero-latency RAM bridge. It adds a configurable RAM read latency, an address window with error response, registered one-cycle acknowledges, and abort handling. It sits between the OpenMIPS Wishbone bus (instruction or data port) and an on-chip synchronous SRAM whose read data returns RD_LAT cycles after it samples the address.

## Interface
- ADDR_WIDTH, 32, Wishbone and RAM address width (byte address)
- DATA_WIDTH, 32, data width
- SEL_WIDTH, DATA_WIDTH/8, byte-select width
- RD_LAT, 1, RAM read latency in cycles; legal range 1..7
- BASE_ADDR, 0, window base; must be aligned to 2^SIZE_LOG2
- SIZE_LOG2, 16, window size is 2^SIZE_LOG2 bytes
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wishbone_cyc_i  in  1  bus cycle
- wishbone_stb_i  in  1  strobe
- wishbone_we_i  in  1  1 = write
- wishbone_addr_i  in  ADDR_WIDTH  byte address
- wishbone_data_i  in  DATA_WIDTH  write data
- wishbone_sel_i  in  SEL_WIDTH  byte lanes
- wishbone_data_o  out  DATA_WIDTH  read data, registered
- wishbone_ack_o  out  1  normal termination, one-cycle pulse
- wishbone_err_o  out  1  error termination, one-cycle pulse
- ram_ce_o  out  1  RAM chip enable, one-cycle pulse per access
- ram_we_o  out  1  RAM write enable, qualified by ram_ce_o
- ram_addr_o  out  ADDR_WIDTH  wishbone_addr_i − BASE_ADDR
- ram_data_o  out  DATA_WIDTH  RAM write data
- ram_sel_o  out  SEL_WIDTH  RAM byte enables
- ram_data_i  in  DATA_WIDTH  RAM read data

## Operation
- Request = wishbone_cyc_i & wishbone_stb_i, sampled only in IDLE.
- FSM states: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE, request, in window and sel_i ≠ 0: register we, addr − BASE_ADDR, data and sel onto the ram_* outputs; ram_ce_o <= 1; go to ACCESS.
- IDLE, request, address outside [BASE_ADDR, BASE_ADDR + 2^SIZE_LOG2) or sel_i == 0: no RAM access; err_o <= 1; go to RESP.
- ACCESS: ram_ce_o <= 0 and ram_we_o <= 0. For a write, ack_o <= cyc_i and go to RESP. For a read, load the 3-bit counter with RD_LAT−1 and go to RD_WAIT.
- RD_WAIT: if the counter is 0, capture ram_data_i into data_o, set ack_o <= cyc_i, and go to RESP. Otherwise decrement the counter.
- RESP: clear ack_o and err_o; go to IDLE. Inputs are ignored here, because the master still holds stb on the edge where it samples ack.
- Abort: if cyc_i is low when ack would be set, the access still completes on the RAM side and data_o is still updated, but ack_o stays 0.
- ram_addr_o, ram_data_o and ram_sel_o hold their values between accesses.
- data_o changes only on a read capture.
- Out-of-range address arithmetic is modulo 2^ADDR_WIDTH; the window compare uses the full address.

## Timing
- Reset values: every output is 0 (ram_ce_o, ram_we_o, ram_addr_o, ram_data_o, ram_sel_o, wishbone_data_o, wishbone_ack_o, wishbone_err_o). FSM = IDLE, counter = 0.
- Reset mid-operation returns to IDLE immediately with all outputs 0. Any pending ack is lost.
- Edge T is the edge at which IDLE samples the request.
- ram_ce_o is high for exactly the cycle after T, and the RAM samples the access at T+1.
- Write: ack_o is high for the cycle after T+1.
- Read: ack_o is high for the cycle after T+1+RD_LAT. data_o is valid in that same cycle and held afterwards.
- Error: err_o is high for the cycle after T.
- Earliest next sample edges: write T+3, read T+3+RD_LAT, error T+2.
- ack_o and err_o are never high together and never high for two consecutive cycles.

## Test plan
- Reset: hold rst_n low with random inputs → all outputs 0. Release reset with no request → ram_ce_o stays 0.
- Write, BASE_ADDR=0x1000_0000, addr 0x1000_0010, data 0xDEAD_BEEF, sel 0xF → ram_ce_o=ram_we_o=1 for 1 cycle with ram_addr_o=0x10, ram_data_o=0xDEAD_BEEF; ack pulse one cycle later.
- Read with RD_LAT=1 and RD_LAT=3: the RAM model returns 0x1234_5678 after RD_LAT cycles → ack rises exactly 2 / 4 cycles after T with data_o=0x1234_5678. The master holds stb one cycle after ack → no second access.
- Errors: addr 0x2000_0000 (out of window) and an in-window access with sel=0x0 → err pulse in the cycle after T, ram_ce_o never asserted, data_o unchanged.
- Abort: start a read with RD_LAT=3, then drop cyc_i in RD_WAIT → no ack, data_o updated, FSM back in IDLE; a following write is then acked normally.
- Back-to-back: 8 alternating writes and reads, each issued as soon as the previous ack is seen → read data matches written data; spacing meets the minimums above; no ack and err overlap.
